// File: rtl/gcd_ci_sequencer_pkg.sv
// Shared definitions for the gcd_ci sequencer: register map, STATUS bit
// positions, the dispatch FSM state type and the queued operand pair layout.
// Used by: gcd_ci_sequencer.
package gcd_ci_sequencer_pkg;

  // Avalon-MM register addresses (word offsets)
  localparam logic [1:0] ADDR_OPA    = 2'd0;
  localparam logic [1:0] ADDR_OPB    = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // STATUS bit indices; result count lives in [15:8]
  localparam int ST_IN_FULL   = 0;
  localparam int ST_RES_EMPTY = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_TIMEOUT   = 3;
  localparam int ST_OVERFLOW  = 4;
  localparam int ST_UNDERFLOW = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

endpackage

// File: rtl/gcd_ci_sequencer_if.sv
// Bus bundle between the CPU-facing Avalon-MM slave / gcd_ci core and the sequencer.
// slave  : sequencer view (Avalon slave, drives the core's custom-instruction inputs).
// master : CPU + gcd_ci view (drives Avalon requests, returns core result/done).
interface gcd_ci_sequencer_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic [31:0] ci_result;
  logic        ci_done;

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read, ci_result, ci_done,
    output avs_readdata, irq, ci_clk_en, ci_start, ci_dataa, ci_datab
  );

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read, ci_result, ci_done,
    input  avs_readdata, irq, ci_clk_en, ci_start, ci_dataa, ci_datab
  );
endinterface

// File: rtl/gcd_ci_sequencer_sync_fifo.sv
// Purpose: single-clock FIFO with show-ahead read data and occupancy count.
// Latency: pushed word visible on pop_dat the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together both take effect.
// Ports: clk/rst, push/push_dat, pop/pop_dat, full, empty, count.
module gcd_ci_sequencer_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/gcd_ci_sequencer.sv
// Purpose: queues operand pairs from an Avalon-MM slave, sequences gcd_ci jobs, queues results for readback.
// Latency: register reads return 1 cycle after avs_read; a job issues 2 cycles after its OPB write at the earliest.
// Backpressure: full input FIFO drops pairs (sticky overflow); full result FIFO holds dispatch in IDLE.
// Ports: clk, reset (async, active high), bus (Avalon slave + gcd_ci start/clk_en/data/result/done).
module gcd_ci_sequencer
  import gcd_ci_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              reset,
  gcd_ci_sequencer_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic wr_opa, wr_opb, wr_status, rd_result, rd_status;
  assign wr_opa    = bus.avs_write && (bus.avs_address == ADDR_OPA);
  assign wr_opb    = bus.avs_write && (bus.avs_address == ADDR_OPB);
  assign wr_status = bus.avs_write && (bus.avs_address == ADDR_STATUS);
  assign rd_result = bus.avs_read  && (bus.avs_address == ADDR_RESULT);
  assign rd_status = bus.avs_read  && (bus.avs_address == ADDR_STATUS);

  logic [31:0] opa_q;
  pair_t       in_push_dat, in_pop_dat;
  logic        in_pop, in_full, in_empty;
  logic [CW-1:0] in_count;
  logic        res_push, res_pop, res_full, res_empty;
  logic [31:0] res_push_dat, res_pop_dat;
  logic [CW-1:0] res_count;

  state_t      state_q, state_d;
  logic [31:0] dataa_q, datab_q;
  logic [WW-1:0] wdog_q;
  logic        load_ops, wdog_clr, wdog_inc, timeout_set, start, clk_en;
  logic        timeout_q, overflow_q, underflow_q;
  logic [31:0] status, readdata_q;
  logic        unused_in_count;

  assign in_push_dat     = '{a: opa_q, b: bus.avs_writedata};
  assign res_pop         = rd_result && !res_empty;
  assign unused_in_count = ^in_count;

  gcd_ci_sequencer_sync_fifo #(.WIDTH($bits(pair_t)), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk(clk), .rst(reset),
    .push(wr_opb), .push_dat(in_push_dat),
    .pop(in_pop), .pop_dat(in_pop_dat),
    .full(in_full), .empty(in_empty), .count(in_count)
  );

  gcd_ci_sequencer_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .clk(clk), .rst(reset),
    .push(res_push), .push_dat(res_push_dat),
    .pop(res_pop), .pop_dat(res_pop_dat),
    .full(res_full), .empty(res_empty), .count(res_count)
  );

  always_comb begin
    status = '0;
    status[ST_IN_FULL]   = in_full;
    status[ST_RES_EMPTY] = res_empty;
    status[ST_BUSY]      = (state_q != S_IDLE);
    status[ST_TIMEOUT]   = timeout_q;
    status[ST_OVERFLOW]  = overflow_q;
    status[ST_UNDERFLOW] = underflow_q;
    status[15:8]         = 8'(res_count);
  end

  // Register file, sticky flags and read data. A flag event in the same cycle
  // as its W1C clear wins so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa_q       <= '0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      readdata_q  <= '0;
    end else begin
      if (wr_opa) opa_q <= bus.avs_writedata;
      if (wr_status) begin
        if (bus.avs_writedata[ST_TIMEOUT])   timeout_q   <= 1'b0;
        if (bus.avs_writedata[ST_OVERFLOW])  overflow_q  <= 1'b0;
        if (bus.avs_writedata[ST_UNDERFLOW]) underflow_q <= 1'b0;
      end
      if (timeout_set)            timeout_q   <= 1'b1;
      if (wr_opb && in_full)      overflow_q  <= 1'b1;
      if (rd_result && res_empty) underflow_q <= 1'b1;
      readdata_q <= '0;
      if (res_pop)   readdata_q <= res_pop_dat;
      if (rd_status) readdata_q <= status;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dataa_q <= '0;
      datab_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_ops) begin
        dataa_q <= in_pop_dat.a;
        datab_q <= in_pop_dat.b;
      end
      if (wdog_clr)      wdog_q <= '0;
      else if (wdog_inc) wdog_q <= wdog_q + WW'(1);
    end
  end

  // Dispatch only when a result slot is free, so the job in flight can
  // always push its result (or the timeout zero) without stalling.
  always_comb begin
    state_d      = state_q;
    in_pop       = 1'b0;
    res_push     = 1'b0;
    res_push_dat = '0;
    load_ops     = 1'b0;
    wdog_clr     = 1'b0;
    wdog_inc     = 1'b0;
    timeout_set  = 1'b0;
    start        = 1'b0;
    clk_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_empty && !res_full) begin
          in_pop = 1'b1;
          if (in_pop_dat.a == '0 || in_pop_dat.b == '0) begin
            // gcd(x,0)=x never terminates in the core; answer it here.
            res_push     = 1'b1;
            res_push_dat = (in_pop_dat.a > in_pop_dat.b) ? in_pop_dat.a : in_pop_dat.b;
          end else begin
            load_ops = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        start    = 1'b1;
        clk_en   = 1'b1;
        wdog_clr = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        clk_en = 1'b1;
        if (bus.ci_done) begin
          res_push     = 1'b1;
          res_push_dat = bus.ci_result;
          state_d      = S_DRAIN;
        end else if (wdog_q == WD_LAST) begin
          res_push    = 1'b1;
          timeout_set = 1'b1;
          state_d     = S_DRAIN;
        end else begin
          wdog_inc = 1'b1;
        end
      end
      // One cycle with clk_en low lets the core drop done before the next issue.
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.avs_readdata = readdata_q;
  assign bus.irq          = !res_empty;
  assign bus.ci_clk_en    = clk_en;
  assign bus.ci_start     = start;
  assign bus.ci_dataa     = dataa_q;
  assign bus.ci_datab     = datab_q;

endmodule

// File: tb/tb_gcd_ci_sequencer.sv
module tb_gcd_ci_sequencer;
  import gcd_ci_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcd_ci_sequencer_if bus();

  gcd_ci_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Behavioural gcd_ci core: subtractive Euclid, one step per enabled cycle,
  // start loads operands, clk_en low clears done. No reset, like the real core.
  logic [31:0] core_a = '0, core_b = '0, core_res = '0;
  logic        core_done = 1'b0;
  always @(posedge clk) begin
    if (!bus.ci_clk_en) core_done <= 1'b0;
    else if (bus.ci_start) begin
      core_a <= bus.ci_dataa;
      core_b <= bus.ci_datab;
      core_done <= 1'b0;
    end else if (!core_done) begin
      if (core_a == core_b) begin
        core_done <= 1'b1;
        core_res  <= core_a;
      end else if (core_a > core_b) core_a <= core_a - core_b;
      else core_b <= core_b - core_a;
    end
  end
  assign bus.ci_result = core_res;
  assign bus.ci_done   = core_done;

  int n_cmp = 0;
  int n_fail = 0;
  int start_cnt = 0;

  logic [31:0] exp_q[$];
  logic [63:0] issue_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result from arithmetic: zero operand -> max; otherwise gcd, unless the
  // subtractive step count (sum of Euclid quotients - 1) exceeds the 64-cycle watchdog.
  function automatic logic [31:0] exp_of(input logic [31:0] a, input logic [31:0] b);
    longint x, y, t, steps;
    if (a == 0 || b == 0) return (a > b) ? a : b;
    x = a; y = b; steps = 0;
    while (y != 0) begin
      steps += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    if (steps - 1 > 60) return 32'd0;
    return 32'(x);
  endfunction

  // Compare process: every RESULT read against the model queue, every ci_start
  // against the expected issue order, start always a single cycle with clk_en.
  logic        rd_pend = 1'b0;
  logic [31:0] rd_exp = '0;
  logic        prev_start = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      rd_pend    = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (rd_pend) chk("rd_result_model", bus.avs_readdata, rd_exp);
      rd_pend = 1'b0;
      if (bus.avs_read && bus.avs_address == ADDR_RESULT) begin
        rd_exp  = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
        rd_pend = 1'b1;
      end
      if (bus.ci_start) begin
        start_cnt++;
        chk("start_with_clk_en", {31'd0, bus.ci_clk_en}, 32'd1);
        chk("start_width", {31'd0, prev_start}, 32'd0);
        chk("issue_expected", {31'd0, issue_q.size() != 0}, 32'd1);
        if (issue_q.size() != 0) begin
          logic [63:0] p;
          p = issue_q.pop_front();
          chk("issue_dataa", bus.ci_dataa, p[63:32]);
          chk("issue_datab", bus.ci_datab, p[31:0]);
        end
      end
      prev_start = bus.ci_start;
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(posedge clk); #1;
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(posedge clk); #1;
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic wr_pair(input logic [31:0] a, input logic [31:0] b, input bit drop);
    bus_wr(ADDR_OPA, a);
    if (!drop) begin
      exp_q.push_back(exp_of(a, b));
      if (a != 0 && b != 0) issue_q.push_back({a, b});
    end
    bus_wr(ADDR_OPB, b);
  endtask

  task automatic wait_results(input int n);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      bus_rd(ADDR_STATUS, s);
      if (s[15:8] == n[7:0] && !s[ST_BUSY]) ok = 1'b1;
    end
    chk("settle", {31'd0, ok}, 32'd1);
  endtask

  task automatic rd_expect(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(name, d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] res8 [8];
    int s0;
    bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_readdata", bus.avs_readdata, 32'd0);
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    chk("rst_start", {31'd0, bus.ci_start}, 32'd0);
    chk("rst_clk_en", {31'd0, bus.ci_clk_en}, 32'd0);
    chk("rst_dataa", bus.ci_dataa, 32'd0);
    reset = 1'b0;
    rd_expect("rst_status", ADDR_STATUS, 32'h2);

    // 1: single job
    s0 = start_cnt;
    wr_pair(48, 18, 0);
    wait_results(1);
    chk("t1_one_start", 32'(start_cnt - s0), 32'd1);
    chk("t1_irq_set", {31'd0, bus.irq}, 32'd1);
    rd_expect("t1_status", ADDR_STATUS, 32'h100);
    rd_expect("t1_gcd_48_18", ADDR_RESULT, 32'd6);
    chk("t1_irq_clr", {31'd0, bus.irq}, 32'd0);
    rd_expect("t1_status_after", ADDR_STATUS, 32'h2);

    // 2: zero operands bypass the core
    s0 = start_cnt;
    wr_pair(0, 35, 0);
    wr_pair(0, 0, 0);
    wr_pair(35, 0, 0);
    wait_results(3);
    chk("t2_no_start", 32'(start_cnt - s0), 32'd0);
    rd_expect("t2_0_35", ADDR_RESULT, 32'd35);
    rd_expect("t2_0_0", ADDR_RESULT, 32'd0);
    rd_expect("t2_35_0", ADDR_RESULT, 32'd35);

    // 3: in-order results, then overflow with result FIFO full blocking dispatch
    wr_pair(12, 8, 0);
    wr_pair(17, 5, 0);
    wr_pair(100, 75, 0);
    wr_pair(7, 7, 0);
    wait_results(4);
    rd_expect("t3_12_8", ADDR_RESULT, 32'd4);
    rd_expect("t3_17_5", ADDR_RESULT, 32'd1);
    rd_expect("t3_100_75", ADDR_RESULT, 32'd25);
    rd_expect("t3_7_7", ADDR_RESULT, 32'd7);
    for (int i = 1; i <= 4; i++) wr_pair(0, 32'(i), 0);
    wait_results(4);
    wr_pair(6, 4, 0);
    wr_pair(10, 4, 0);
    wr_pair(21, 14, 0);
    wr_pair(5, 5, 0);
    wr_pair(3, 9, 1);
    rd_expect("t3_overflow_status", ADDR_STATUS, 32'h411);
    bus_wr(ADDR_STATUS, 32'h10);
    res8 = '{1, 2, 3, 4, 2, 2, 7, 5};
    for (int i = 0; i < 4; i++) rd_expect("t3_drain_a", ADDR_RESULT, res8[i]);
    wait_results(4);
    rd_expect("t3_status_refill", ADDR_STATUS, 32'h400);
    for (int i = 4; i < 8; i++) rd_expect("t3_drain_b", ADDR_RESULT, res8[i]);

    // 4: watchdog
    wr_pair(1000000, 1, 0);
    wait_results(1);
    rd_expect("t4_status_timeout", ADDR_STATUS, 32'h108);
    rd_expect("t4_result_zero", ADDR_RESULT, 32'd0);
    bus_wr(ADDR_STATUS, 32'h8);
    rd_expect("t4_status_cleared", ADDR_STATUS, 32'h2);

    // 6: underflow, then pop of last entry concurrent with a push
    rd_expect("t6_underflow_data", ADDR_RESULT, 32'd0);
    rd_expect("t6_underflow_status", ADDR_STATUS, 32'h22);
    bus_wr(ADDR_STATUS, 32'h20);
    rd_expect("t6_status_cleared", ADDR_STATUS, 32'h2);
    wr_pair(0, 5, 0);
    wait_results(1);
    bus_wr(ADDR_OPA, 0);
    @(posedge clk); #1;
    bus.avs_address = ADDR_OPB; bus.avs_writedata = 32'd9; bus.avs_write = 1'b1;
    exp_q.push_back(32'd9);
    @(posedge clk); #1;
    bus.avs_write = 1'b0; bus.avs_address = ADDR_RESULT; bus.avs_read = 1'b1;
    @(posedge clk); #1;
    bus.avs_read = 1'b0;
    chk("t6_concurrent_pop", bus.avs_readdata, 32'd5);
    rd_expect("t6_count_kept", ADDR_STATUS, 32'h100);
    rd_expect("t6_pushed_word", ADDR_RESULT, 32'd9);
    rd_expect("t6_status_end", ADDR_STATUS, 32'h2);

    // 5: reset in the middle of WAIT
    wr_pair(1000, 3, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (bus.ci_start) seen = 1'b1;
      end
      chk("t5_start_seen", {31'd0, seen}, 32'd1);
    end
    repeat (5) @(negedge clk);
    chk("t5_in_wait_clk_en", {31'd0, bus.ci_clk_en}, 32'd1);
    #2 reset = 1'b1;
    exp_q.delete();
    issue_q.delete();
    #1;
    chk("t5_async_clk_en", {31'd0, bus.ci_clk_en}, 32'd0);
    chk("t5_async_start", {31'd0, bus.ci_start}, 32'd0);
    chk("t5_async_dataa", bus.ci_dataa, 32'd0);
    chk("t5_async_datab", bus.ci_datab, 32'd0);
    chk("t5_async_irq", {31'd0, bus.irq}, 32'd0);
    chk("t5_async_readdata", bus.avs_readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd_expect("t5_status_after_reset", ADDR_STATUS, 32'h2);
    wr_pair(9, 6, 0);
    wait_results(1);
    rd_expect("t5_gcd_9_6", ADDR_RESULT, 32'd3);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
